// File: rtl/jt6295_mixer.sv
// jt6295_mixer: sums four time-multiplexed channel samples per frame,
// applies a power-of-two gain and emits one mixed sample per cen_sr frame.
// Optional build macro JT6295_MIXER_SAT_EN: clamp the output instead of wrapping.
module jt6295_mixer #(
    parameter int IW   = 12,
    parameter int OW   = 16,
    parameter int GAIN = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cen_sr,
    input  logic                 cen_sr4,
    input  logic                 ch_valid,
    input  logic signed [IW-1:0] ch_data,
    output logic                 ch_ready,
    output logic [1:0]           slot,
    output logic signed [OW-1:0] sound,
    output logic                 sample,
    output logic                 locked,
    output logic                 err
);

    localparam int AW = IW + 2;  // four IW-bit samples always fit
    localparam int SW = OW + 4;  // headroom for the gain shift

    logic [1:0]           slot_q,   slot_d;
    logic signed [AW-1:0] acc_q,    acc_d;
    logic signed [OW-1:0] sound_q,  sound_d;
    logic                 sample_q, sample_d;
    logic                 locked_q, locked_d;
    logic                 err_q,    err_d;
    logic                 filled_q, filled_d;

    logic signed [AW-1:0] data_ext;
    logic signed [SW-1:0] scaled;
    logic signed [OW-1:0] final_val;

    assign data_ext = {{2{ch_data[IW-1]}}, ch_data};
    assign ch_ready = locked_q & ~filled_q;

    // Scale the frame sum and reduce it to the output width.
    always_comb begin
        scaled = {{(SW-AW){acc_q[AW-1]}}, acc_q} <<< GAIN;
`ifdef JT6295_MIXER_SAT_EN
        if (scaled > $signed({{(SW-OW+1){1'b0}}, {(OW-1){1'b1}}})) begin
            final_val = {1'b0, {(OW-1){1'b1}}};
        end else if (scaled < $signed({{(SW-OW+1){1'b1}}, {(OW-1){1'b0}}})) begin
            final_val = {1'b1, {(OW-1){1'b0}}};
        end else begin
            final_val = scaled[OW-1:0];
        end
`else
        final_val = OW'(scaled);
`endif
    end

    // Slot counter, sample acceptance and frame close.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        slot_d   = slot_q;
        acc_d    = acc_q;
        sound_d  = sound_q;
        sample_d = 1'b0;
        locked_d = locked_q;
        err_d    = err_q;
        filled_d = filled_q;
        if (cen_sr) begin
            // A sample arriving with the frame strobe opens slot 0 of the new frame.
            slot_d   = 2'd0;
            locked_d = 1'b1;
            filled_d = ch_valid;
            acc_d    = ch_valid ? data_ext : '0;
            if (locked_q) begin
                sound_d  = final_val;
                sample_d = 1'b1;
            end
        end else begin
            if (ch_valid) begin
                if (ch_ready) begin
                    acc_d    = acc_q + data_ext;
                    filled_d = 1'b1;
                end else if (locked_q) begin
                    err_d = 1'b1;
                end
            end
            if (cen_sr4) begin
                if (slot_q == 2'd3) begin
                    err_d = 1'b1;
                end else begin
                    slot_d   = slot_q + 2'd1;
                    filled_d = 1'b0;
                end
            end
        end
    end

    // State registers; reset discards any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q   <= 2'd0;
            acc_q    <= '0;
            sound_q  <= '0;
            sample_q <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            filled_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            slot_q   <= slot_d;
            acc_q    <= acc_d;
            sound_q  <= sound_d;
            sample_q <= sample_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            filled_q <= filled_d;
        end
    end

    assign slot   = slot_q;
    assign sound  = sound_q;
    assign sample = sample_q;
    assign locked = locked_q;
    assign err    = err_q;

endmodule

// File: tb/tb_jt6295_mixer.sv
// Bench for jt6295_mixer: a default instance (OW=16, GAIN=0) and a gain instance
// (OW=14, GAIN=2) share one stimulus stream.
module tb_jt6295_mixer;

    localparam int IW = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cen_sr = 1'b0, cen_sr4 = 1'b0, ch_valid = 1'b0;
    logic signed [IW-1:0] ch_data = '0;

    logic rdy0, rdy1, sample0, sample1, locked0, locked1, err0, err1;
    logic [1:0] slot0, slot1;
    logic signed [15:0] sound0;
    logic signed [13:0] sound1;

    int checks = 0;
    int errors = 0;

    jt6295_mixer #(.IW(IW), .OW(16), .GAIN(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .cen_sr(cen_sr), .cen_sr4(cen_sr4),
        .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(rdy0), .slot(slot0),
        .sound(sound0), .sample(sample0), .locked(locked0), .err(err0)
    );

    jt6295_mixer #(.IW(IW), .OW(14), .GAIN(2)) u_dut_g (
        .clk(clk), .rst_n(rst_n), .cen_sr(cen_sr), .cen_sr4(cen_sr4),
        .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(rdy1), .slot(slot1),
        .sound(sound1), .sample(sample1), .locked(locked1), .err(err1)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference model: per-frame table of accepted samples, summed at frame close.
    bit     m_locked, m_err, m_sample;
    int     m_slot;
    bit     m_set[4];
    longint m_val[4];
    longint m_sound0, m_sound1;

    function automatic longint fv(longint sum, int ow, int gain);
        longint one = 1;
        longint lim = one <<< (ow - 1);
        longint s = sum * (one <<< gain);
        longint r;
`ifdef JT6295_MIXER_SAT_EN
        if (s > lim - 1) return lim - 1;
        if (s < -lim) return -lim;
        return s;
`else
        r = s % (2 * lim);
        if (r < 0) r += 2 * lim;
        if (r >= lim) r -= 2 * lim;
        return r;
`endif
    endfunction

    task automatic model_reset();
        m_locked = 0; m_err = 0; m_sample = 0; m_slot = 0;
        m_sound0 = 0; m_sound1 = 0;
        for (int i = 0; i < 4; i++) begin m_set[i] = 0; m_val[i] = 0; end
    endtask

    task automatic check(string name, longint act, longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, advance the model, settle after posedge.
    task automatic step(bit sr, bit sr4, bit v, int d);
        longint sum;
        bit rdy;
        @(negedge clk);
        cen_sr = sr; cen_sr4 = sr4; ch_valid = v; ch_data = IW'(d);
        rdy = m_locked && !m_set[m_slot];
        if (sr) begin
            m_sample = m_locked;
            if (m_locked) begin
                sum = 0;
                for (int i = 0; i < 4; i++) if (m_set[i]) sum += m_val[i];
                m_sound0 = fv(sum, 16, 0);
                m_sound1 = fv(sum, 14, 2);
            end
            for (int i = 0; i < 4; i++) begin m_set[i] = 0; m_val[i] = 0; end
            m_slot = 0;
            m_locked = 1;
            if (v) begin m_set[0] = 1; m_val[0] = d; end
        end else begin
            m_sample = 0;
            if (v) begin
                if (rdy) begin m_set[m_slot] = 1; m_val[m_slot] = d; end
                else if (m_locked) m_err = 1;
            end
            if (sr4) begin
                if (m_slot == 3) m_err = 1;
                else m_slot++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_check();
        check("rnd_slot",   slot0,   m_slot);
        check("rnd_ready",  rdy0,    m_locked && !m_set[m_slot]);
        check("rnd_sample", sample0, m_sample);
        check("rnd_sound",  sound0,  m_sound0);
        check("rnd_err",    err0,    m_err);
        check("rnd_locked", locked0, m_locked);
        check("rnd_sample_g", sample1, m_sample);
        check("rnd_sound_g",  sound1,  m_sound1);
        check("rnd_err_g",    err1,    m_err);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 0; cen_sr = 0; cen_sr4 = 0; ch_valid = 0; ch_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    typedef struct {
        bit sr, sr4, v;
        int d;
        int e_slot;
        bit e_rdy, e_smp;
        int e_snd;
        bit e_err;
    } vec_t;

    vec_t tbl[9];
    int   gap;
    int   dat;

    initial begin
        // Basic mix: slots carry 100, -50, 7, 0x7FF, closed by cen_sr.
        tbl[0] = '{0, 0, 1,  100, 0, 0, 0,    0, 0};
        tbl[1] = '{0, 1, 0,    0, 1, 1, 0,    0, 0};
        tbl[2] = '{0, 0, 1,  -50, 1, 0, 0,    0, 0};
        tbl[3] = '{0, 1, 0,    0, 2, 1, 0,    0, 0};
        tbl[4] = '{0, 0, 1,    7, 2, 0, 0,    0, 0};
        tbl[5] = '{0, 1, 0,    0, 3, 1, 0,    0, 0};
        tbl[6] = '{0, 0, 1, 2047, 3, 0, 0,    0, 0};
        tbl[7] = '{1, 1, 0,    0, 0, 1, 1, 2104, 0};
        tbl[8] = '{0, 0, 0,    0, 0, 1, 0, 2104, 0};

        // Reset state
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_slot", slot0, 0);
        check("rst_sound", sound0, 0);
        check("rst_sample", sample0, 0);
        check("rst_locked", locked0, 0);
        check("rst_err", err0, 0);
        check("rst_ready", rdy0, 0);
        rst_n = 1;

        // Lock: pre-lock valid is ignored without err; first cen_sr gives no sample
        step(0, 0, 1, 100);
        check("prelock_ready", rdy0, 0);
        check("prelock_err", err0, 0);
        check("prelock_locked", locked0, 0);
        step(1, 1, 0, 0);
        check("lock_locked", locked0, 1);
        check("lock_sample", sample0, 0);
        check("lock_ready", rdy0, 1);

        for (int i = 0; i < 9; i++) begin
            step(tbl[i].sr, tbl[i].sr4, tbl[i].v, tbl[i].d);
            check($sformatf("tbl%0d_slot", i), slot0, tbl[i].e_slot);
            check($sformatf("tbl%0d_ready", i), rdy0, tbl[i].e_rdy);
            check($sformatf("tbl%0d_sample", i), sample0, tbl[i].e_smp);
            check($sformatf("tbl%0d_sound", i), sound0, tbl[i].e_snd);
            check($sformatf("tbl%0d_err", i), err0, tbl[i].e_err);
        end

        // Missing and duplicate samples
        step(0, 1, 0, 0);
        step(0, 0, 1, 5);
        check("dup_first_ready", rdy0, 0);
        check("dup_first_err", err0, 0);
        step(0, 0, 1, 9);
        check("dup_err", err0, 1);
        step(0, 0, 0, 0);
        check("dup_ready_hold", rdy0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 1, -3);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        check("dup_sample", sample0, 1);
        check("dup_sound", sound0, 2);
        check("dup_err_sticky", err0, 1);

        // Overrun: fifth cen_sr4 in one frame
        apply_reset();
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        check("ovr_slot3", slot0, 3);
        check("ovr_no_err", err0, 0);
        step(0, 1, 0, 0);
        check("ovr_slot_hold", slot0, 3);
        check("ovr_err", err0, 1);
        step(1, 1, 0, 0);
        check("ovr_restart_slot", slot0, 0);
        check("ovr_sample", sample0, 1);
        check("ovr_sound", sound0, 0);

        // Gain and output reduction: all slots at full scale
        step(0, 0, 1, 2047);
        step(0, 1, 0, 0);
        step(0, 0, 1, 2047);
        step(0, 1, 0, 0);
        step(0, 0, 1, 2047);
        step(0, 1, 0, 0);
        step(0, 0, 1, 2047);
        step(1, 1, 0, 0);
        check("gain0_sound", sound0, 8188);
        check("gain2_sample", sample1, 1);
`ifdef JT6295_MIXER_SAT_EN
        check("gain2_sound", sound1, 8191);
`else
        check("gain2_sound", sound1, -16);
`endif

        // Async reset mid-frame after two accepts
        step(0, 0, 1, 10);
        step(0, 1, 0, 0);
        step(0, 0, 1, 20);
        #2 rst_n = 0;
        #1;
        check("arst_slot", slot0, 0);
        check("arst_sound", sound0, 0);
        check("arst_sound_g", sound1, 0);
        check("arst_locked", locked0, 0);
        check("arst_err", err0, 0);
        check("arst_ready", rdy0, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        step(1, 1, 0, 0);
        check("arst_relock_sample", sample0, 0);
        step(0, 0, 1, 1);
        step(0, 1, 0, 0);
        step(0, 0, 1, 2);
        step(0, 1, 0, 0);
        step(0, 0, 1, 3);
        step(0, 1, 0, 0);
        step(0, 0, 1, 4);
        step(1, 1, 0, 0);
        check("arst_next_sound", sound0, 10);
        check("arst_next_sound_g", sound1, 40);

        // Randomized frames against the reference model
        apply_reset();
        step(1, 1, 0, 0);
        model_check();
        for (int f = 0; f < 40; f++) begin
            for (int s = 0; s < 4; s++) begin
                gap = $urandom_range(1, 3);
                for (int g = 0; g < gap; g++) begin
                    dat = int'($urandom_range(0, 4095)) - 2048;
                    step(0, 0, 1'($urandom_range(0, 1)), dat);
                    model_check();
                end
                if (s < 3) begin
                    step(0, 1, 0, 0);
                    model_check();
                end
            end
            if (f % 7 == 3) begin
                step(0, 1, 0, 0);
                model_check();
            end
            dat = int'($urandom_range(0, 4095)) - 2048;
            step(1, 1, 1'($urandom_range(0, 3) == 0), dat);
            model_check();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
